// File: rtl/epp_pkg.sv
// Shared encodings for the EPP host master: command ops, FSM states and
// the sizing helper for the shared setup/hold/timeout down-counter.
package epp_pkg;

  typedef enum logic [1:0] {
    OP_ADDR_WR = 2'd0,
    OP_DATA_WR = 2'd1,
    OP_ADDR_RD = 2'd2,
    OP_DATA_RD = 2'd3
  } epp_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    HOLD,
    DONE
  } epp_state_e;

  localparam int CNT_MIN_W = 8;

  function automatic int bits_for(input int v);
    return (v <= 0) ? 1 : $clog2(v + 1);
  endfunction

  // Counter must hold the largest of the three loads, and never be narrower than a byte.
  function automatic int cnt_width(input int setup_cyc, input int hold_cyc, input int timeout_cyc);
    int w;
    w = CNT_MIN_W;
    if (bits_for(setup_cyc) > w) w = bits_for(setup_cyc);
    if (bits_for(hold_cyc) > w) w = bits_for(hold_cyc);
    if (bits_for(timeout_cyc) > w) w = bits_for(timeout_cyc);
    return w;
  endfunction

  function automatic logic op_is_read(input epp_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_addr(input epp_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/epp_wait_sync.sv
// Two-flop synchronizer bringing the device's eppWait handshake into clk.
module epp_wait_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/epp_host_master.sv
// EPP host-side master: runs one address/data read or write cycle per command.
// Define EPP_HOST_TIMEOUT_EN to abort stalled STROBE/RELEASE waits after TIMEOUT_CYC clocks.
module epp_host_master
  import epp_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [1:0] cmdOp,
  input  logic [7:0] cmdData,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       rspTimeout,
  output logic       stbAddr,
  output logic       stbData,
  output logic       ctrlWr,
  output logic [7:0] busEppOut,
  output logic       busEppOe,
  input  logic [7:0] busEppIn,
  input  logic       eppWait
);

  localparam int CNT_W = cnt_width(SETUP_CYC, HOLD_CYC, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  epp_state_e       state_q, state_d;
  epp_op_e          op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             stb_addr_q, stb_addr_d;
  logic             stb_data_q, stb_data_d;
  logic             ctrl_wr_q, ctrl_wr_d;
  logic [7:0]       bus_out_q, bus_out_d;
  logic             bus_oe_q, bus_oe_d;
  logic             wait_sync;
  logic             drive_phase;
  logic             is_wr;
`ifdef EPP_HOST_TIMEOUT_EN
  logic             tmo_hit;
  logic             abort_q, abort_d;
  logic             rsp_timeout_q, rsp_timeout_d;
`endif

  epp_wait_sync u_wait_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (eppWait),
    .q     (wait_sync)
  );

  // Every state entry reloads the single shared counter with that state's budget.
  function automatic logic [CNT_W-1:0] entry_load(input epp_state_e st);
    case (st)
      SETUP:           return SETUP_LD;
      STROBE, RELEASE: return TMO_LD;
      HOLD:            return HOLD_LD;
      default:         return '0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
`ifdef EPP_HOST_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmdValid) begin
          op_d    = epp_op_e'(cmdOp);
          data_d  = cmdData;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) state_d = STROBE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      STROBE: begin
        if (wait_sync) begin
          if (op_is_read(op_q)) rsp_data_d = busEppIn;
          state_d = RELEASE;
        end
`ifdef EPP_HOST_TIMEOUT_EN
        else if (cnt_q == '0) begin
          tmo_hit = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      RELEASE: begin
        if (!wait_sync) state_d = HOLD;
`ifdef EPP_HOST_TIMEOUT_EN
        else if (cnt_q == '0) begin
          tmo_hit = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      HOLD: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = entry_load(state_d);
  end

  // Bus outputs are registered from the next state so they line up with state_q.
  always_comb begin
    drive_phase = (state_d == SETUP) || (state_d == STROBE) ||
                  (state_d == RELEASE) || (state_d == HOLD);
    is_wr       = ~op_is_read(op_d);
    stb_addr_d  = ~((state_d == STROBE) && op_is_addr(op_d));
    stb_data_d  = ~((state_d == STROBE) && ~op_is_addr(op_d));
    ctrl_wr_d   = ~(drive_phase && is_wr);
    bus_oe_d    = drive_phase && is_wr;
    bus_out_d   = bus_oe_d ? data_d : 8'h00;
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADDR_WR;
      data_q      <= 8'h00;
      cnt_q       <= '0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      stb_addr_q  <= 1'b1;
      stb_data_q  <= 1'b1;
      ctrl_wr_q   <= 1'b1;
      bus_out_q   <= 8'h00;
      bus_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      stb_addr_q  <= stb_addr_d;
      stb_data_q  <= stb_data_d;
      ctrl_wr_q   <= ctrl_wr_d;
      bus_out_q   <= bus_out_d;
      bus_oe_q    <= bus_oe_d;
    end
  end

`ifdef EPP_HOST_TIMEOUT_EN
  // The abort flag survives through HOLD so DONE can report it.
  always_comb begin
    abort_d       = abort_q;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == IDLE && cmdValid) abort_d = 1'b0;
    if (tmo_hit)                     abort_d = 1'b1;
    if (state_d == DONE)             rsp_timeout_d = abort_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q       <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      abort_q       <= abort_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rspTimeout = rsp_timeout_q;
`else
  assign rspTimeout = 1'b0;
`endif

  assign cmdReady  = (state_q == IDLE);
  assign rspValid  = rsp_valid_q;
  assign rspData   = rsp_data_q;
  assign stbAddr   = stb_addr_q;
  assign stbData   = stb_data_q;
  assign ctrlWr    = ctrl_wr_q;
  assign busEppOut = bus_out_q;
  assign busEppOe  = bus_oe_q;

endmodule

// File: tb/tb_epp_host_master.sv
// Scoreboard bench for epp_host_master with a simple EPP device model.
module tb_epp_host_master;
  import epp_pkg::*;

  localparam int SETUP_CYC   = 2;
  localparam int HOLD_CYC    = 2;
  localparam int TIMEOUT_CYC = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmdValid = 1'b0;
  logic [1:0] cmdOp = 2'd0;
  logic [7:0] cmdData = 8'h00;
  logic       cmdReady, rspValid, rspTimeout;
  logic [7:0] rspData, busEppOut;
  logic       stbAddr, stbData, ctrlWr, busEppOe;
  logic [7:0] busEppIn = 8'h00;
  logic       eppWait = 1'b0;

  always #5 clk = ~clk;

  epp_host_master #(
    .SETUP_CYC   (SETUP_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdOp      (cmdOp),
    .cmdData    (cmdData),
    .rspValid   (rspValid),
    .rspData    (rspData),
    .rspTimeout (rspTimeout),
    .stbAddr    (stbAddr),
    .stbData    (stbData),
    .ctrlWr     (ctrlWr),
    .busEppOut  (busEppOut),
    .busEppOe   (busEppOe),
    .busEppIn   (busEppIn),
    .eppWait    (eppWait)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] exp_rsp;
    logic       exp_tmo;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Device: acks a strobe after ack_delay clocks, drops eppWait once strobes release.
  int         ack_delay = 3;
  bit         dev_tie0 = 1'b0;
  logic [7:0] dev_byte = 8'h00;
  int         dev_cnt = 0;

  always @(negedge clk) begin
    if (!stbAddr || !stbData) begin
      if (!eppWait && !dev_tie0) begin
        if (dev_cnt >= ack_delay) begin
          eppWait  = 1'b1;
          busEppIn = dev_byte;
        end else begin
          dev_cnt++;
        end
      end
    end else begin
      dev_cnt  = 0;
      eppWait  = 1'b0;
      busEppIn = 8'h00;
    end
  end

  // Bus monitor and response checker.
  int setup_cnt = 0, low_cnt = 0, hold_cnt = 0, n_fall = 0, rsp_seen = 0;
  bit viol = 1'b0, stb_low_prev = 1'b0;

  always @(negedge clk) begin
    bit         stb_low;
    bit         is_wr;
    bit         is_addr;
    logic [7:0] wdata;
    txn_t       e;
    if (!rst_n) begin
      setup_cnt = 0; low_cnt = 0; hold_cnt = 0; n_fall = 0;
      viol = 1'b0; stb_low_prev = 1'b0;
    end else begin
      stb_low = !stbAddr || !stbData;
      if (sb.size() > 0) begin
        is_wr = !sb[0].op[1]; is_addr = !sb[0].op[0]; wdata = sb[0].data;
      end else begin
        is_wr = 1'b0; is_addr = 1'b0; wdata = 8'h00;
      end
      if (stb_low && !stb_low_prev) begin
        n_fall++;
        check_eq("stb_sel", 32'({stbAddr, stbData}), is_addr ? 32'd1 : 32'd2);
        check_eq("setup_cyc", 32'(setup_cnt), 32'(SETUP_CYC));
        check_eq("ctrl_wr_setup", 32'(ctrlWr), 32'(!is_wr));
        check_eq("oe_setup", 32'(busEppOe), 32'(is_wr));
        if (is_wr) check_eq("out_setup", 32'(busEppOut), 32'(wdata));
      end
      if (stb_low) begin
        low_cnt++;
        if ((!stbAddr && !stbData) || ctrlWr !== !is_wr || busEppOe !== is_wr ||
            (is_wr && busEppOut !== wdata)) viol = 1'b1;
      end else if (n_fall > 0 && !rspValid) begin
        if (ctrlWr === !is_wr && busEppOe === is_wr && (!is_wr || busEppOut === wdata))
          hold_cnt++;
      end else if (n_fall == 0 && !cmdReady && !rspValid) begin
        setup_cnt++;
      end
      if (rspValid) begin
        rsp_seen++;
        check_eq("rsp_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("txn op=%0d data=%02h rsp_data=%02h rsp_tmo=%0b strobe_clks=%0d",
                   e.op, e.data, rspData, rspTimeout, low_cnt);
          check_eq("rsp_data", 32'(rspData), 32'(e.exp_rsp));
          check_eq("rsp_tmo", 32'(rspTimeout), 32'(e.exp_tmo));
          check_eq("done_ctrl_wr", 32'(ctrlWr), 32'd1);
          check_eq("done_oe", 32'(busEppOe), 32'd0);
          check_eq("stb_pulses", 32'(n_fall), 32'd1);
          check_eq("stb_viol", 32'(viol), 32'd0);
          check_eq("hold_cyc_ok", 32'(hold_cnt >= HOLD_CYC), 32'd1);
          if (e.exp_tmo) check_eq("tmo_width", 32'(low_cnt), 32'(TIMEOUT_CYC));
        end
        setup_cnt = 0; low_cnt = 0; hold_cnt = 0; n_fall = 0; viol = 1'b0;
      end
      stb_low_prev = stb_low;
    end
  end

  logic [7:0] last_rd = 8'h00;

  task automatic send(input logic [1:0] op, input logic [7:0] data,
                      input logic [7:0] rd_byte, input bit tmo);
    txn_t t;
    int   n;
    n = 0;
    @(negedge clk);
    while (!cmdReady && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) begin
      check_eq("accept_wait", 32'(cmdReady), 32'd1);
    end else begin
      dev_byte = rd_byte;
      if (op[1] && !tmo) last_rd = rd_byte;
      t.op = op; t.data = data; t.exp_rsp = last_rd; t.exp_tmo = tmo;
      sb.push_back(t);
      cmdValid = 1'b1; cmdOp = op; cmdData = data;
      @(posedge clk);
      #1 cmdValid = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_wait", 32'(sb.size()), 32'd0);
  endtask

  task automatic strobe_reset(input logic [7:0] exp_rsp_data);
    int n;
    int rs;
    n = 0;
    while (stbAddr && stbData && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("strobe_seen", 32'(stbAddr && stbData), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_stb_addr", 32'(stbAddr), 32'd1);
    check_eq("rst_stb_data", 32'(stbData), 32'd1);
    check_eq("rst_ctrl_wr", 32'(ctrlWr), 32'd1);
    check_eq("rst_oe", 32'(busEppOe), 32'd0);
    sb.delete();
    last_rd = 8'h00;
    rs = rsp_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rst_ready", 32'(cmdReady), 32'd1);
    check_eq("rst_no_rsp", 32'(rsp_seen - rs), 32'd0);
    check_eq("rst_rsp_data", 32'(rspData), 32'(exp_rsp_data));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_stbAddr", 32'(stbAddr), 32'd1);
    check_eq("rst_stbData", 32'(stbData), 32'd1);
    check_eq("rst_ctrlWr", 32'(ctrlWr), 32'd1);
    check_eq("rst_busEppOe", 32'(busEppOe), 32'd0);
    check_eq("rst_busEppOut", 32'(busEppOut), 32'd0);
    check_eq("rst_rspValid", 32'(rspValid), 32'd0);
    check_eq("rst_rspData", 32'(rspData), 32'd0);
    check_eq("rst_rspTimeout", 32'(rspTimeout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_cmdReady", 32'(cmdReady), 32'd1);

    // Directed address write, data write, data read.
    ack_delay = 3;
    send(2'd0, 8'h40, 8'h00, 1'b0);
    send(2'd1, 8'h44, 8'h00, 1'b0);
    send(2'd3, 8'h00, 8'hA5, 1'b0);
    send(2'd1, 8'h11, 8'h00, 1'b0);
    send(2'd2, 8'h00, 8'h3C, 1'b0);
    wait_rsp(500);

    // Mixed traffic with varying device latency.
    for (int i = 0; i < 10; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      ack_delay = int'($urandom_range(0, 5));
      send(op, 8'($urandom), 8'($urandom), 1'b0);
    end
    wait_rsp(2000);

    // Device never acknowledges.
    dev_tie0 = 1'b1;
`ifdef EPP_HOST_TIMEOUT_EN
    send(2'd0, 8'h77, 8'h00, 1'b1);
    send(2'd3, 8'h00, 8'h99, 1'b1);
    wait_rsp(1200);
    dev_tie0 = 1'b0;
`else
    send(2'd0, 8'h77, 8'h00, 1'b0);
    repeat (1000) @(negedge clk);
    check_eq("hang_no_rsp", 32'(sb.size()), 32'd1);
    check_eq("hang_stb_held", 32'(stbAddr), 32'd0);
    strobe_reset(8'h00);
    dev_tie0 = 1'b0;
`endif

    // Reset in the middle of a read strobe.
    ack_delay = 20;
    send(2'd0, 8'h12, 8'h00, 1'b0);
    wait_rsp(500);
    send(2'd3, 8'h00, 8'h5A, 1'b0);
    strobe_reset(8'h00);

    // Recovery after reset: write response reflects the cleared read register.
    ack_delay = 2;
    send(2'd1, 8'h5E, 8'h00, 1'b0);
    send(2'd3, 8'h00, 8'hC3, 1'b0);
    send(2'd0, 8'h01, 8'h00, 1'b0);
    wait_rsp(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/epp_host_master.md
EPP_HOST_MASTER -- requirements
Module: epp_host_master

Interface
REQ-001 Parameter SETUP_CYC, default 2: clocks that data/ctrlWr are held stable before the strobe falls.
REQ-002 Parameter HOLD_CYC, default 2: clocks that data/ctrlWr are held after the strobe rises.
REQ-003 Parameter TIMEOUT_CYC, default 255: maximum clocks spent waiting for each eppWait edge.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmdValid  in  1  command request.
REQ-007 cmdReady  out  1  high in IDLE only; a command is accepted when cmdValid&cmdReady.
REQ-008 cmdOp  in  2  operation: 0 address write, 1 data write, 2 address read, 3 data read.
REQ-009 cmdData  in  8  write byte (ignored for reads).
REQ-010 rspValid  out  1  one-clock pulse at command completion.
REQ-011 rspData  out  8  read byte; valid with rspValid.
REQ-012 rspTimeout  out  1  command aborted by timeout; valid with rspValid.
REQ-013 stbAddr  out  1  EPP address strobe, active low.
REQ-014 stbData  out  1  EPP data strobe, active low.
REQ-015 ctrlWr  out  1  EPP write enable, active low (0 = write).
REQ-016 busEppOut  out  8  byte driven toward device.
REQ-017 busEppOe  out  1  high while the host drives busEppOut.
REQ-018 busEppIn  in  8  byte returned by device.
REQ-019 eppWait  in  1  device handshake, asynchronous; high = strobe acknowledged.

Function
REQ-020 eppWait shall pass through a two-flop synchronizer; all handshake decisions use the synchronized value.
REQ-021 FSM states shall be IDLE, SETUP, STROBE, RELEASE, HOLD, DONE.
REQ-022 IDLE: on accept, latch cmdOp/cmdData and go to SETUP on the next clock.
REQ-023 SETUP: ctrlWr=0 and busEppOe=1 with busEppOut=latched byte for writes, ctrlWr=1 and busEppOe=0 for reads; advance to STROBE after SETUP_CYC clocks.
REQ-024 STROBE: drive stbAddr low (ops 0/2) or stbData low (ops 1/3), never both; on synchronized eppWait=1, capture busEppIn into rspData for reads and go to RELEASE.
REQ-025 RELEASE: both strobes high; on synchronized eppWait=0 go to HOLD.
REQ-026 HOLD: keep ctrlWr/busEppOut/busEppOe from SETUP for HOLD_CYC clocks, then go to DONE.
REQ-027 DONE: pulse rspValid one clock, drive ctrlWr=1 and busEppOe=0, return to IDLE; a new command is accepted no earlier than the clock after DONE.
REQ-028 A single down-counter of at least 8 bits shall serve SETUP/HOLD counts and timeout counts; it reloads on every state entry.
REQ-029 Write responses shall hold rspData at its previous value; rspTimeout shall be 0 on normal completion.

Reset
REQ-030 On rst_n=0, immediately: state=IDLE, stbAddr=1, stbData=1, ctrlWr=1, busEppOe=0, busEppOut=0, rspValid=0, rspData=0, rspTimeout=0, synchronizer=0, counter=0.
REQ-031 Reset during any state (including STROBE) shall release strobes asynchronously; no rspValid is issued for the aborted command.

Configuration
REQ-032 Macro EPP_HOST_TIMEOUT_EN defined: if STROBE or RELEASE lasts TIMEOUT_CYC clocks without the expected eppWait level, go to HOLD, strobes high, and complete with rspTimeout=1 (rspData unchanged).
REQ-033 Macro undefined: STROBE/RELEASE wait indefinitely; rspTimeout is constant 0.

Structure
REQ-034 Package epp_pkg shall hold the cmdOp encodings and the FSM state enumeration.
REQ-035 Sub-module epp_wait_sync (two-flop synchronizer, async-reset to 0) shall be instantiated once.

Verification
REQ-036 Op0 data 0x40, device model acks after 3 clocks -> stbAddr low 1 strobe, busEppOut=0x40, ctrlWr=0 spanning it, rspValid with rspTimeout=0.
REQ-037 Op1 data 0x44 immediately after -> stbData low only, busEppOut=0x44, stbAddr stays 1 throughout.
REQ-038 Op3, device drives busEppIn=0xA5 with eppWait -> rspData=0xA5, ctrlWr=1 and busEppOe=0 for the whole cycle.
REQ-039 eppWait tied 0, EPP_HOST_TIMEOUT_EN defined -> strobe released after 255 clocks, rspValid with rspTimeout=1; undefined -> strobe held, no rspValid after 1000 clocks.
REQ-040 rst_n pulsed low mid-STROBE -> stbAddr/stbData=1 before the next clock edge, no rspValid, cmdReady=1 after release.
